// File: rtl/jtcps1_cfg_pkg.sv
// Shared constants and FSM encoding for the CPS-B config loader.
// Define JTCPS1_CFG_CHECKSUM_EN to add a trailing checksum byte.
package jtcps1_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_HI,
    SEND_LO,
    DONE
  } cfg_st_t;

  localparam int CFG_REGSIZE = 23;
  localparam logic [21:0] CFG_START_DEF = 22'h3F_FFE0;

`ifdef JTCPS1_CFG_CHECKSUM_EN
  localparam int CK_LEN = 1;
`else
  localparam int CK_LEN = 0;
`endif

endpackage

// File: rtl/jtcps1_cfg_loader_if.sv
// Download-side inputs and MMR-side config strobe outputs.
// master = loader, slave = download/MMR environment.
interface jtcps1_cfg_loader_if;

  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        replay;
  logic        cfg_we;
  logic [7:0]  cfg_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    input  downloading, ioctl_addr, ioctl_data,
    input  ioctl_wr, replay,
    output cfg_we, cfg_data, cfg_busy,
    output cfg_done, cfg_err
  );

  modport slave (
    output downloading, ioctl_addr, ioctl_data,
    output ioctl_wr, replay,
    input  cfg_we, cfg_data, cfg_busy,
    input  cfg_done, cfg_err
  );

endinterface

// File: rtl/jtcps1_cfg_buf.sv
// Config byte buffer with per-byte capture mask.
// With JTCPS1_CFG_CHECKSUM_EN the window and mask include the checksum byte.
module jtcps1_cfg_buf
  import jtcps1_cfg_pkg::*;
#(
  parameter int          DEPTH = CFG_REGSIZE + CK_LEN,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [21:0] BASE  = CFG_START_DEF
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr,
  input  logic [21:0]   addr,
  input  logic [7:0]    din,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          full
`ifdef JTCPS1_CFG_CHECKSUM_EN
  ,
  output logic [7:0]    sum
`endif
);

  localparam logic [21:0] DEPTH_A = 22'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [21:0]      off;
  logic             hit;

  // below-window addresses wrap to huge offsets
  assign off = addr - BASE;
  assign hit = wr && (off < DEPTH_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      mask <= '0;
    end else begin
      if (clr)
        mask <= '0;
      if (hit) begin
        mem[off[AW-1:0]]  <= din;
        mask[off[AW-1:0]] <= 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_idx];
  assign full    = &mask;

`ifdef JTCPS1_CFG_CHECKSUM_EN
  always_comb begin
    sum = '0;
    for (int i = 0; i < DEPTH; i++)
      sum = sum + mem[i];
  end
`endif

endmodule

// File: rtl/jtcps1_cfg_loader.sv
// Captures the CPS-B config window from the ROM download and replays it
// to the MMR shift register. JTCPS1_CFG_CHECKSUM_EN gates on a checksum.
module jtcps1_cfg_loader
  import jtcps1_cfg_pkg::*;
#(
  parameter int          REGSIZE   = CFG_REGSIZE,
  parameter logic [21:0] CFG_START = CFG_START_DEF,
  parameter int          HI_LEN    = 2,
  parameter int          LO_LEN    = 2
)(
  input logic                 clk,
  input logic                 rst,
  jtcps1_cfg_loader_if.master bus
);

  localparam int DEPTH = REGSIZE + CK_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int MX    = (HI_LEN > LO_LEN) ? HI_LEN : LO_LEN;
  localparam int CW    = $clog2(MX + 1);

  localparam logic [CW-1:0] HI_C  = CW'(HI_LEN);
  localparam logic [CW-1:0] LO_C  = CW'(LO_LEN);
  localparam logic [CW-1:0] LO_M1 = CW'(LO_LEN - 1);
  localparam logic [AW-1:0] TOP   = AW'(REGSIZE - 1);

  cfg_st_t       st;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] cnt;
  logic          dl_q;
  logic          rp_q;
  logic          dl_rise;
  logic          rp_rise;
  logic          clr;
  logic          full;
  logic          more;
  logic [7:0]    rd_data;
`ifdef JTCPS1_CFG_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign dl_rise = bus.downloading & ~dl_q;
  assign rp_rise = bus.replay & ~rp_q;
  assign clr     = dl_rise && (st != LOAD);
  assign more    = (idx != '0);
  // while sending, prefetch the next (lower) byte
  assign rd_idx  = (st == SEND_HI || st == SEND_LO) ?
                   idx - AW'(1) : TOP;

  jtcps1_cfg_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .BASE  (CFG_START)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr      (bus.ioctl_wr),
    .addr    (bus.ioctl_addr),
    .din     (bus.ioctl_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .full    (full)
`ifdef JTCPS1_CFG_CHECKSUM_EN
    ,
    .sum     (sum)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      dl_q         <= 1'b0;
      rp_q         <= 1'b0;
      bus.cfg_we   <= 1'b0;
      bus.cfg_data <= '0;
      bus.cfg_busy <= 1'b0;
      bus.cfg_done <= 1'b0;
      bus.cfg_err  <= 1'b0;
    end else begin
      dl_q <= bus.downloading;
      rp_q <= bus.replay;
      if (clr) begin
        st           <= LOAD;
        bus.cfg_we   <= 1'b0;
        bus.cfg_busy <= 1'b0;
        bus.cfg_done <= 1'b0;
        bus.cfg_err  <= 1'b0;
      end else begin
        unique case (st)
          IDLE, DONE: begin
            if (rp_rise) begin
              st           <= SEND_HI;
              idx          <= TOP;
              bus.cfg_busy <= 1'b1;
              bus.cfg_data <= rd_data;
            end
          end
          LOAD: begin
            if (!bus.downloading) begin
`ifdef JTCPS1_CFG_CHECKSUM_EN
              if (!full || sum != 8'd0) begin
                st          <= DONE;
                bus.cfg_err <= 1'b1;
              end else begin
                st           <= SEND_HI;
                idx          <= TOP;
                bus.cfg_busy <= 1'b1;
                bus.cfg_data <= rd_data;
              end
`else
              st           <= SEND_HI;
              idx          <= TOP;
              bus.cfg_busy <= 1'b1;
              bus.cfg_data <= rd_data;
              bus.cfg_err  <= !full;
`endif
            end
          end
          SEND_HI: begin
            // first byte enters with cfg_we low: data setup cycle
            if (!bus.cfg_we) begin
              bus.cfg_we <= 1'b1;
              cnt        <= CW'(1);
            end else if (cnt == HI_C) begin
              bus.cfg_we <= 1'b0;
              cnt        <= CW'(1);
              st         <= SEND_LO;
              if (LO_LEN == 1 && more)
                bus.cfg_data <= rd_data;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SEND_LO: begin
            if (cnt == LO_C) begin
              if (!more) begin
                st           <= DONE;
                bus.cfg_busy <= 1'b0;
                bus.cfg_done <= !bus.cfg_err;
              end else begin
                idx        <= idx - AW'(1);
                bus.cfg_we <= 1'b1;
                cnt        <= CW'(1);
                st         <= SEND_HI;
              end
            end else begin
              cnt <= cnt + CW'(1);
              if (cnt == LO_M1 && more)
                bus.cfg_data <= rd_data;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
